// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared types and constants for the register hazard controller slice.
package reg_hazard_ctrl_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int REG_W         = 32;
    localparam int REG_NUM       = 32;
    localparam int LU_FIFO_DEPTH = 2;

    localparam logic             ENABLE    = 1'b1;
    localparam logic             DISABLE   = 1'b0;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_word_t;

    // One buffered long-latency result waiting for the write port.
    typedef struct packed {
        reg_addr_t rd;
        reg_word_t data;
    } wb_entry_t;

    // x0 is hardwired to zero: never tracked, never written.
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/reg_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID read/issue info, MEM/WB
// write, long-latency unit result handshake, regfile write port and stall.
interface reg_hazard_ctrl_if #(
    parameter int REG_NUM = 32
);
    import reg_hazard_ctrl_pkg::*;

    logic               re1;
    logic               re2;
    reg_addr_t          raddr1;
    reg_addr_t          raddr2;
    logic               issue_valid;
    logic               issue_long;
    reg_addr_t          issue_rd;
    logic               flush;
    logic               wb_we;
    reg_addr_t          wb_waddr;
    reg_word_t          wb_wdata;
    logic               lu_valid;
    reg_addr_t          lu_rd;
    reg_word_t          lu_data;
    logic               lu_ready;
    logic               rf_we;
    reg_addr_t          rf_waddr;
    reg_word_t          rf_wdata;
    logic               stallreq;
    logic [REG_NUM-1:0] busy;

    // Pipeline / LU side.
    modport master (
        output re1, re2, raddr1, raddr2,
        output issue_valid, issue_long, issue_rd, flush,
        output wb_we, wb_waddr, wb_wdata,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, stallreq, busy
    );

    // Controller side.
    modport slave (
        input  re1, re2, raddr1, raddr2,
        input  issue_valid, issue_long, issue_rd, flush,
        input  wb_we, wb_waddr, wb_wdata,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready, rf_we, rf_waddr, rf_wdata, stallreq, busy
    );

endinterface

// File: rtl/reg_hazard_ctrl_fifo.sv
// reg_wb_fifo: small circular buffer of LU results waiting for the regfile
// write port. Push is refused when full; pop is refused when empty.
module reg_wb_fifo
    import reg_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage: data only, no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Register scoreboard, RAW/WAW stall generation and regfile write-port
// arbitration between MEM/WB and the long-latency unit.
module reg_hazard_ctrl
    import reg_hazard_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = LU_FIFO_DEPTH,
    parameter int REG_NUM    = 32
) (
    input  logic            clk,
    input  logic            rst,
    reg_hazard_ctrl_if.slave bus
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] clr_mask;

    logic      stall;
    logic      issue_ok;
    logic      lu_ready;
    logic      lu_acc;
    logic      wb_sel;
    logic      pop;
    logic      bypass;
    logic      push;
    logic      lu_wr;
    reg_addr_t lu_wr_rd;

    logic      fifo_full;
    logic      fifo_empty;
    wb_entry_t fifo_head;
    wb_entry_t fifo_din;

    logic      rf_we;
    reg_addr_t rf_waddr;
    reg_word_t rf_wdata;

    // Hazard check uses only registered busy: a result written this cycle
    // still stalls its consumer for one more cycle.
    always_comb begin
        stall = ~rst & ((bus.re1 & busy_q[bus.raddr1]) |
                        (bus.re2 & busy_q[bus.raddr2]) |
                        (bus.issue_valid & bus.issue_long & busy_q[bus.issue_rd]));
    end

    assign issue_ok = bus.issue_valid & bus.issue_long & ~stall & ~bus.flush &
                      ~is_x0(bus.issue_rd);

    // Ready comes from the registered count so a same-cycle pop never frees
    // a slot for a push.
    assign lu_ready = ~rst & ~fifo_full;
    assign lu_acc   = bus.lu_valid & lu_ready;

    // Write-port priority: MEM/WB, then buffered LU results, then LU bypass.
    assign wb_sel = ~rst & bus.wb_we & ~is_x0(bus.wb_waddr);
    assign pop    = ~rst & ~wb_sel & ~fifo_empty;
    assign bypass = ~wb_sel & fifo_empty & lu_acc;
    assign push   = lu_acc & ~bypass;

    assign lu_wr    = pop | bypass;
    assign lu_wr_rd = pop ? fifo_head.rd : bus.lu_rd;

    assign fifo_din = '{rd: bus.lu_rd, data: bus.lu_data};

    reg_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Regfile write port mux.
    always_comb begin
        rf_we    = DISABLE;
        rf_waddr = '0;
        rf_wdata = ZERO_WORD;
        if (wb_sel) begin
            rf_we    = ENABLE;
            rf_waddr = bus.wb_waddr;
            rf_wdata = bus.wb_wdata;
        end else if (pop) begin
            rf_we    = ENABLE;
            rf_waddr = fifo_head.rd;
            rf_wdata = fifo_head.data;
        end else if (bypass) begin
            rf_we    = ENABLE;
            rf_waddr = bus.lu_rd;
            rf_wdata = bus.lu_data;
        end
    end

    // Next scoreboard: set on accepted long issue, clear when the LU result
    // reaches the port; x0 is forced idle.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_ok) begin
            set_mask[bus.issue_rd] = 1'b1;
        end
        if (lu_wr) begin
            clr_mask[lu_wr_rd] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Scoreboard register; reset drops all outstanding tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.lu_ready = lu_ready;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;
    assign bus.stallreq = stall;
    assign bus.busy     = busy_q;

    // The WAW stall keeps set and clear of one register apart.
    a_no_set_clr: assert property (@(posedge clk) disable iff (rst)
        (set_mask & clr_mask) == '0);

    // MEM/WB must never target a register still owed by the LU.
    a_wb_not_busy: assert property (@(posedge clk) disable iff (rst)
        !(wb_sel && busy_q[bus.wb_waddr]));

    // Every LU result must belong to an outstanding register.
    a_lu_busy: assert property (@(posedge clk) disable iff (rst)
        !(lu_acc && !busy_q[bus.lu_rd]));

endmodule
